// File: rtl/fft_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module   : fft_peak_detector
//  Purpose  : Streams complex FFT bins, computes per-bin power re^2+im^2 and
//             reports the index and power of the strongest bin of each
//             well-formed frame. Malformed frames are dropped with a
//             one-cycle frame_err pulse.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             in_valid/sop/eop  - bin sample qualifiers (sop/eop need valid)
//             in_real/in_imag   - signed DATA_W complex bin value
//             peak_valid        - one-cycle pulse, 3 cycles after a good eop
//             peak_bin          - index of the max-power bin (held)
//             peak_power        - power of that bin (held)
//             frame_err         - one-cycle pulse, 1 cycle after the error
//  Options  : FFT_PEAK_HALF_SPECTRUM_EN - when defined, only bins
//             0..FFT_LEN/2-1 take part in the max search.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_peak_detector #(
  parameter int DATA_W  = 14,
  parameter int FFT_LEN = 1024,
  parameter int BIN_W   = $clog2(FFT_LEN),
  parameter int POW_W   = 2 * DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     peak_valid,
  output logic [BIN_W-1:0]         peak_bin,
  output logic [POW_W-1:0]         peak_power,
  output logic                     frame_err
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_cnt, bin_cnt_nxt;

  // Framing decisions for the sample presented this cycle
  logic             acc_valid;     // sample enters the pipeline
  logic [BIN_W-1:0] acc_bin;       // its bin index within the frame
  logic             acc_good_eop;  // it closes a well-formed frame
  logic             err_nxt;       // it makes the current frame malformed

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bin_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bin_cnt <= bin_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bin_cnt_nxt  = bin_cnt;
    acc_valid    = 1'b0;
    acc_bin      = '0;
    acc_good_eop = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_sop) begin
          acc_valid = 1'b1;
          if (in_eop) begin
            // eop on bin 0 can never be the last bin (FFT_LEN >= 4)
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt   = ACCUM;
            bin_cnt_nxt = BIN_W'(1);
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_valid = 1'b1;
          if (in_sop) begin
            // Restart: the partial frame is dropped and this sample becomes
            // bin 0; bin 0 reloads the running max so nothing leaks across.
            err_nxt = 1'b1;
            if (in_eop) begin
              state_nxt = IDLE;
            end else begin
              state_nxt   = ACCUM;
              bin_cnt_nxt = BIN_W'(1);
            end
          end else begin
            acc_bin = bin_cnt;
            if (bin_cnt == LAST_BIN) begin
              state_nxt = IDLE;
              if (in_eop) begin
                acc_good_eop = 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end else if (in_eop) begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end else begin
              bin_cnt_nxt = bin_cnt + BIN_W'(1);
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // S1: squares. Operands are sign-extended to POW_W so the products of
  // two negative values come out positive without truncation.
  // --------------------------------------------------------------------------
  logic signed [POW_W-1:0] re_ext, im_ext;
  assign re_ext = POW_W'(in_real);
  assign im_ext = POW_W'(in_imag);

  logic             s1_valid, s1_eop;
  logic [BIN_W-1:0] s1_bin;
  logic [POW_W-1:0] s1_re2, s1_im2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_eop   <= 1'b0;
      s1_bin   <= '0;
      s1_re2   <= '0;
      s1_im2   <= '0;
    end else begin
      s1_valid <= acc_valid;
      s1_eop   <= acc_good_eop;
      if (acc_valid) begin
        s1_bin <= acc_bin;
        s1_re2 <= $unsigned(re_ext * re_ext);
        s1_im2 <= $unsigned(im_ext * im_ext);
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2: power sum. Max is 2 * 2^(2*DATA_W-2) = 2^(POW_W-1), so it fits.
  // --------------------------------------------------------------------------
  logic             s2_valid, s2_eop;
  logic [BIN_W-1:0] s2_bin;
  logic [POW_W-1:0] s2_pow;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_eop   <= 1'b0;
      s2_bin   <= '0;
      s2_pow   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_eop   <= s1_eop;
      if (s1_valid) begin
        s2_bin <= s1_bin;
        s2_pow <= s1_re2 + s1_im2;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3: compare/update of the running max, and result publication
  // --------------------------------------------------------------------------
  logic             in_search;
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
  // Real-input spectra are symmetric; the upper half carries no new peak.
  assign in_search = (s2_bin[BIN_W-1] == 1'b0);
`else
  assign in_search = 1'b1;
`endif

  logic [BIN_W-1:0] max_bin, cand_bin;
  logic [POW_W-1:0] max_pow, cand_pow;
  logic             take;

  always_comb begin
    take = 1'b0;
    if (s2_valid) begin
      if (s2_bin == '0) begin
        take = 1'b1;                          // new frame: reload
      end else if (in_search && (s2_pow > max_pow)) begin
        take = 1'b1;                          // strict: ties keep lowest bin
      end
    end
    cand_bin = take ? s2_bin : max_bin;
    cand_pow = take ? s2_pow : max_pow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_bin    <= '0;
      max_pow    <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_power <= '0;
      frame_err  <= 1'b0;
    end else begin
      max_bin    <= cand_bin;
      max_pow    <= cand_pow;
      peak_valid <= s2_valid && s2_eop;
      frame_err  <= err_nxt;
      if (s2_valid && s2_eop) begin
        peak_bin   <= cand_bin;
        peak_power <= cand_pow;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_peak_detector
//  Purpose  : Directed self-checking bench for fft_peak_detector with a
//             16-bin frame: peak search, full-scale power, ties, framing
//             errors, back-to-back frames with bubbles, and mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_peak_detector;

  localparam int DATA_W  = 14;
  localparam int FFT_LEN = 16;
  localparam int BIN_W   = 4;
  localparam int POW_W   = 28;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid, in_sop, in_eop;
  logic signed [DATA_W-1:0] in_real, in_imag;
  logic                     peak_valid, frame_err;
  logic [BIN_W-1:0]         peak_bin;
  logic [POW_W-1:0]         peak_power;

  fft_peak_detector #(
    .DATA_W (DATA_W),
    .FFT_LEN(FFT_LEN),
    .BIN_W  (BIN_W),
    .POW_W  (POW_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .peak_valid(peak_valid),
    .peak_bin  (peak_bin),
    .peak_power(peak_power),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Cycle counter and output event log, sampled 2 time units after posedge
  int         cyc     = 0;
  int         err_cnt = 0;
  int         err_cyc = -1;
  logic [3:0] pb_q[$];
  logic [27:0] pp_q[$];
  int         pc_q[$];

  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (peak_valid) begin
      pb_q.push_back(peak_bin);
      pp_q.push_back(peak_power);
      pc_q.push_back(cyc);
    end
  end

  // Frame contents by bin, and cycle stamps of the last send
  logic signed [DATA_W-1:0] fr_re [FFT_LEN];
  logic signed [DATA_W-1:0] fr_im [FFT_LEN];
  int first_cyc, last_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int b = 0; b < FFT_LEN; b++) begin
      fr_re[b] = '0;
      fr_im[b] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
    end
  endtask

  // Drive bins first..last; random bubbles (with junk qualifiers) before every
  // sample but the first, so a new frame's sop can follow the previous eop.
  task automatic send_bins(input int first, input int last, input bit sop_first,
                           input bit eop_last, input int gap_pct);
    for (int b = first; b <= last; b++) begin
      if (b != first) begin
        while ($urandom_range(0, 99) < gap_pct) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_sop   = 1'($urandom_range(0, 1));
          in_eop   = 1'($urandom_range(0, 1));
          in_real  = DATA_W'($urandom);
          in_imag  = DATA_W'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = sop_first && (b == first);
      in_eop   = eop_last && (b == last);
      in_real  = fr_re[b];
      in_imag  = fr_im[b];
      if (b == first) first_cyc = cyc;
      last_cyc = cyc;
    end
  endtask

  // After an eop sample: no pulse at +1/+2, pulse with data at +3, gone at +4
  task automatic expect_peak(input string tag, input int bin, input int pow);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      if (k == 3) begin
        check({tag, "_valid"}, 32'(peak_valid), 1);
        check({tag, "_bin"}, 32'(peak_bin), bin);
        check({tag, "_power"}, 32'(peak_power), pow);
      end else begin
        check({tag, "_quiet"}, 32'(peak_valid), 0);
      end
    end
  endtask

  initial begin
    int pbase, ebase;
    begin : watchdog
      fork
        begin
          #200000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "watchdog");
        end
      join_none
    end

    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_real  = '0;
    in_imag  = '0;
    clear_frame();
    repeat (3) @(negedge clk);
    check("rst_peak_valid", 32'(peak_valid), 0);
    check("rst_peak_bin", 32'(peak_bin), 0);
    check("rst_peak_power", 32'(peak_power), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    idle(2);

    // Single tone at bin 5: 100^2 + 50^2 = 12500
    clear_frame();
    fr_re[5] = 14'sd100;
    fr_im[5] = -14'sd50;
    send_bins(0, 15, 1, 1, 0);
    expect_peak("tone5", 5, 12500);
    check("tone5_hold_bin", 32'(peak_bin), 5);

    // Full-scale: 2 * 8192^2 = 134217728
    clear_frame();
    fr_re[3] = 14'sh2000;
    fr_im[3] = 14'sh2000;
    send_bins(0, 15, 1, 1, 0);
    expect_peak("fullscale", 3, 134217728);

    // Tie at 90000 between bins 2 and 9: lowest index wins
    clear_frame();
    fr_re[2] = 14'sd300;
    fr_re[9] = 14'sd300;
    send_bins(0, 15, 1, 1, 0);
    expect_peak("tie", 2, 90000);

    // Lone upper-half tone at bin 12 (400^2 = 160000)
    clear_frame();
    fr_re[12] = 14'sd400;
    send_bins(0, 15, 1, 1, 0);
`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    expect_peak("upper12", 0, 0);
`else
    expect_peak("upper12", 12, 160000);
`endif

    // eop at bin 7: error 1 cycle later, no pulse
    pbase = pb_q.size();
    ebase = err_cnt;
    clear_frame();
    fr_re[1] = 14'sd1000;
    send_bins(0, 7, 1, 1, 0);
    idle(1);
    check("eop7_err_pulse", 32'(frame_err), 1);
    idle(1);
    check("eop7_err_width", 32'(frame_err), 0);
    idle(4);
    check("eop7_err_count", 32'(err_cnt - ebase), 1);
    check("eop7_err_time", 32'(err_cyc - last_cyc), 1);
    check("eop7_no_pulse", 32'(pb_q.size() - pbase), 0);

    // sop at bin 4 restarts; the clean frame peaks at bin 7: 400+900 = 1300
    ebase = err_cnt;
    clear_frame();
    fr_re[2] = 14'sd2000;
    send_bins(0, 3, 1, 0, 0);
    clear_frame();
    fr_re[7] = -14'sd20;
    fr_im[7] = 14'sd30;
    send_bins(0, 15, 1, 1, 0);
    check("restart_err_time", 32'(err_cyc - first_cyc), 1);
    expect_peak("restart", 7, 1300);
    check("restart_err_count", 32'(err_cnt - ebase), 1);

    // Last bin without eop: error; stray non-sop samples afterwards ignored
    pbase = pb_q.size();
    ebase = err_cnt;
    clear_frame();
    fr_re[4] = 14'sd50;
    send_bins(0, 15, 1, 0, 0);
    send_bins(0, 3, 0, 0, 0);
    send_bins(4, 4, 0, 1, 0);
    idle(5);
    check("noeop_err_count", 32'(err_cnt - ebase), 1);
    check("noeop_no_pulse", 32'(pb_q.size() - pbase), 0);

    // Back-to-back frames with ~30% bubbles: peaks bin 5 (1e6) then 11 (490000)
    begin
      int a_eop;
      pbase = pb_q.size();
      ebase = err_cnt;
      for (int b = 0; b < FFT_LEN; b++) begin
        fr_re[b] = 14'(b);
        fr_im[b] = '0;
      end
      fr_re[5] = 14'sd1000;
      send_bins(0, 15, 1, 1, 30);
      a_eop = last_cyc;
      fr_re[5]  = 14'sd5;
      fr_re[11] = '0;
      fr_im[11] = -14'sd700;
      send_bins(0, 15, 1, 1, 30);
      idle(6);
      check("b2b_pulses", 32'(pb_q.size() - pbase), 2);
      check("b2b_no_err", 32'(err_cnt - ebase), 0);
      if (pb_q.size() - pbase == 2) begin
        check("b2b_a_bin", 32'(pb_q[pbase]), 5);
        check("b2b_a_power", 32'(pp_q[pbase]), 1000000);
        check("b2b_a_time", 32'(pc_q[pbase] - a_eop), 3);
        check("b2b_b_bin", 32'(pb_q[pbase+1]), 11);
        check("b2b_b_power", 32'(pp_q[pbase+1]), 490000);
        check("b2b_b_time", 32'(pc_q[pbase+1] - last_cyc), 3);
      end
    end

    // Reset asserted with bin 8 of a frame
    pbase = pb_q.size();
    ebase = err_cnt;
    clear_frame();
    fr_re[3] = 14'sd2000;
    send_bins(0, 7, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_real  = 14'sd7;
    in_imag  = '0;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst_peak_valid", 32'(peak_valid), 0);
    check("midrst_peak_bin", 32'(peak_bin), 0);
    check("midrst_peak_power", 32'(peak_power), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(6);
    check("midrst_no_pulse", 32'(pb_q.size() - pbase), 0);
    check("midrst_no_err", 32'(err_cnt - ebase), 0);

    // Clean frame after reset: bin 1, 25+25 = 50
    clear_frame();
    fr_re[1] = 14'sd5;
    fr_im[1] = 14'sd5;
    send_bins(0, 15, 1, 1, 0);
    expect_peak("postrst", 1, 50);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
